reg_file_ctrl: RTL and testbench
================================

// Module: reg_file_ctrl
// PURPOSE
//  Command-side master for the 3-entry register file: accepts LOAD/MOVE/READ/CLEAR commands over
//  a valid/ready handshake and drives the file's one-hot SEL, ADDR, IN and RZ pins.
//  Hides the file's one-cycle registered read and returns READ data to the host with a valid strobe.
//  Sits between the instruction decoder and the register file.
// PARAMETERS
//  WIDTH   8  data width of IMM, RF_IN, RF_OUT, RD_DATA
//  RD_LAT  1  register-file read latency in cycles (ADDR sample edge to OUT valid); range 1..3
// PORTS
//  CLK        in   1      system clock, all logic on rising edge
//  RST        in   1      reset, asynchronous, active-high
//  CMD_VALID  in   1      command present
//  CMD_READY  out  1      controller idle, command accepted at edge when VALID&READY
//  CMD_OP     in   2      00 LOAD imm->dst, 01 MOVE src->dst, 10 READ src->host, 11 CLEAR dst
//  CMD_DST    in   2      destination 0..2; 3 illegal for LOAD/MOVE/CLEAR
//  CMD_SRC    in   2      source 0..2, 3 = zero register (RZ)
//  CMD_IMM    in   WIDTH  immediate for LOAD
//  RF_SEL     out  3      one-hot write select to register file (000 = no write)
//  RF_ADDR    out  2      read address to register file
//  RF_IN      out  WIDTH  write data to register file
//  RF_RZ      out  1      zero-register input to register file, constant 0
//  RF_OUT     in   WIDTH  registered read data from register file
//  RD_DATA    out  WIDTH  READ result, valid while RD_VALID
//  RD_VALID   out  1      one-cycle READ completion strobe
//  ERR        out  1      one-cycle pulse: illegal destination, command dropped
// BEHAVIOUR
//  - Reset (async): state IDLE; RF_SEL=000, RF_ADDR=00, RF_IN=0, RD_DATA=0, RD_VALID=0, ERR=0,
//    CMD_READY=0 while RST high, 1 from first cycle after release. RF_RZ always 0.
//  - Reset mid-command aborts it: no write issued after RST rises, RD_VALID/ERR never emitted.
//  - All outputs registered. CMD_READY=1 only in IDLE; one command in flight at a time.
//  - FSM: IDLE, WAIT, CAP, WRITE, RESP, FAULT.
//  - IDLE: on accept edge E0 latch command.
//      dst==3 and op!=READ -> FAULT. LOAD -> WRITE (RF_IN=IMM). CLEAR -> WRITE (RF_IN=0).
//      MOVE/READ -> WAIT, RF_ADDR=SRC, held until CAP exits.
//  - WAIT: RD_LAT cycles (counter), file samples RF_ADDR. -> CAP.
//  - CAP: 1 cycle, RF_OUT valid; sampled at edge ending CAP. MOVE -> WRITE (RF_IN=RF_OUT);
//    READ -> RESP (RD_DATA=RF_OUT).
//  - WRITE: 1 cycle, RF_SEL=1<<dst, file writes at edge ending WRITE; RF_SEL back to 000. -> IDLE.
//  - RESP: RD_VALID=1 one cycle, RD_DATA held until next READ. -> IDLE.
//  - FAULT: ERR=1 one cycle, RF_SEL stays 000. -> IDLE.
//  - Latency accept->IDLE: LOAD/CLEAR 2 cycles; MOVE/READ RD_LAT+3 cycles (RD_LAT=1: 4).
//  - RF_SEL never has more than one bit set; never nonzero outside WRITE.
//  - MOVE src==dst legal (rewrites same value). READ/MOVE src=3 yields 0 (RZ zero-extended).
//  - CMD_* ignored when CMD_READY=0; no queueing.
// CONFIGURATION
//  RF_SHADOW_EN defined: controller keeps shadow copies of R0..R2 plus per-entry valid bits
//   (cleared by RST, set on every WRITE it issues). MOVE/READ with valid shadow (or src=3)
//   skip WAIT/CAP: MOVE -> WRITE, READ -> RESP on the cycle after accept (latency 2).
//   Invalid shadow entry falls back to file path. RF_ADDR still driven = SRC.
//  RF_SHADOW_EN undefined: no shadow storage; all MOVE/READ use WAIT/CAP path.
// TESTING
//  1 LOAD dst=1 IMM=0x5A -> RF_SEL=010, RF_IN=0x5A for exactly 1 cycle, CMD_READY back 2 cycles after accept.
//  2 LOAD R0=0x3C, MOVE src=0 dst=2 -> RF_ADDR=00 held 2 cycles, then RF_SEL=100 RF_IN=0x3C; READ src=2 -> RD_VALID 1 cycle, RD_DATA=0x3C.
//  3 READ src=3 -> RD_DATA=0x00, RD_VALID pulse; CLEAR dst=1 then READ src=1 -> 0x00.
//  4 LOAD dst=3 IMM=0xFF -> ERR pulse 1 cycle, RF_SEL stays 000 throughout, READY 2 cycles after accept.
//  5 Assert RST during WAIT of MOVE -> outputs zero immediately, no RF_SEL pulse, no RD_VALID; next LOAD works.
//  6 RF_SHADOW_EN: LOAD R1=0x77 then READ src=1 -> RD_VALID 2 cycles after accept; READ src=0 unwritten -> file path, RD_LAT+3.

Source files
------------

// File: rtl/reg_file_ctrl.sv
// Command-side controller for the 3-entry register file: LOAD/MOVE/READ/CLEAR over valid/ready.
// Optional shadow copies of R0..R2 enabled by defining RF_SHADOW_EN.
module reg_file_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_dst,
  input  logic [1:0]       cmd_src,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [2:0]       rf_sel,
  output logic [1:0]       rf_addr,
  output logic [WIDTH-1:0] rf_in,
  output logic             rf_rz,
  input  logic [WIDTH-1:0] rf_out,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             err
);

  localparam logic [1:0] OpLoad  = 2'd0;
  localparam logic [1:0] OpMove  = 2'd1;
  localparam logic [1:0] OpRead  = 2'd2;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWait  = 3'd1;
  localparam logic [2:0] StCap   = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StResp  = 3'd4;
  localparam logic [2:0] StFault = 3'd5;

  localparam logic [1:0] CntInit = 2'(RD_LAT - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       dst_q, dst_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [2:0]       sel_q, sel_d;
  logic [1:0]       addr_q, addr_d;
  logic [WIDTH-1:0] in_q, in_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             err_q, err_d;

  logic             shadow_hit;
  logic [WIDTH-1:0] shadow_val;

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

`ifdef RF_SHADOW_EN
  logic [WIDTH-1:0] shadow_q [3];
  logic [2:0]       shadow_vld_q;

  // Source 3 is the zero register, so it always counts as a hit.
  always_comb begin
    shadow_hit = 1'b1;
    shadow_val = '0;
    case (cmd_src)
      2'd0: begin
        shadow_hit = shadow_vld_q[0];
        shadow_val = shadow_q[0];
      end
      2'd1: begin
        shadow_hit = shadow_vld_q[1];
        shadow_val = shadow_q[1];
      end
      2'd2: begin
        shadow_hit = shadow_vld_q[2];
        shadow_val = shadow_q[2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_vld_q <= '0;
      for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
    end else if (|sel_d) begin
      shadow_q[dst_d]     <= in_d;
      shadow_vld_q[dst_d] <= 1'b1;
    end
  end
`else
  assign shadow_hit = 1'b0;
  assign shadow_val = '0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    sel_d      = '0;
    addr_d     = addr_q;
    in_d       = in_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid && ready_q) begin
          op_d  = cmd_op;
          dst_d = cmd_dst;
          if (cmd_dst == 2'd3 && cmd_op != OpRead) begin
            state_d = StFault;
            err_d   = 1'b1;
          end else if (cmd_op == OpLoad || cmd_op == 2'd3) begin
            state_d = StWrite;
            sel_d   = onehot(cmd_dst);
            in_d    = (cmd_op == OpLoad) ? cmd_imm : '0;
          end else begin
            addr_d = cmd_src;
            if (shadow_hit && cmd_op == OpMove) begin
              state_d = StWrite;
              sel_d   = onehot(cmd_dst);
              in_d    = shadow_val;
            end else if (shadow_hit) begin
              state_d    = StResp;
              rd_data_d  = shadow_val;
              rd_valid_d = 1'b1;
            end else begin
              state_d = StWait;
              cnt_d   = CntInit;
            end
          end
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) state_d = StCap;
        else               cnt_d   = cnt_q - 2'd1;
      end
      StCap: begin
        if (op_q == OpMove) begin
          state_d = StWrite;
          sel_d   = onehot(dst_q);
          in_d    = rf_out;
        end else begin
          state_d    = StResp;
          rd_data_d  = rf_out;
          rd_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      in_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      in_q       <= in_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rf_sel    = sel_q;
  assign rf_addr   = addr_q;
  assign rf_in     = in_q;
  assign rf_rz     = 1'b0;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: register-file model, transaction-level reference, directed + random.
module tb_reg_file_ctrl;
  localparam int WIDTH  = 8;
  localparam int RD_LAT = 1;
`ifdef RF_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif
  localparam logic [1:0] LOAD = 2'd0, MOVE = 2'd1, READ = 2'd2, CLEAR = 2'd3;
  localparam int KW = 1, KR = 2, KE = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0, cmd_dst = '0, cmd_src = '0;
  logic [WIDTH-1:0] cmd_imm = '0;
  logic [2:0]       rf_sel;
  logic [1:0]       rf_addr;
  logic [WIDTH-1:0] rf_in, rf_out, rd_data;
  logic             rf_rz, rd_valid, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_ctrl #(.WIDTH(WIDTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm), .rf_sel(rf_sel),
    .rf_addr(rf_addr), .rf_in(rf_in), .rf_rz(rf_rz), .rf_out(rf_out), .rd_data(rd_data),
    .rd_valid(rd_valid), .err(err)
  );

  // Register file: writes on rf_sel, registered read with RD_LAT stages, addr 3 reads RZ.
  logic [7:0] mem [3] = '{8'h11, 8'h22, 8'h33};
  logic [7:0] pipe [3] = '{default: 8'h00};
  always @(posedge clk) begin
    pipe[0] <= (rf_addr == 2'd3) ? {7'd0, rf_rz} : mem[rf_addr];
    for (int i = 1; i < 3; i++) pipe[i] <= pipe[i-1];
    for (int i = 0; i < 3; i++) if (rf_sel[i]) mem[i] <= rf_in;
  end
  assign rf_out = pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: register contents, shadow validity, and one pending event per command.
  logic [7:0] regs [3] = '{8'h11, 8'h22, 8'h33};
  bit         vld [3];
  int         cyc = 0, ready_at = 1 << 30;
  int         ev_kind = 0, ev_cyc = 0, ev_dst = 0;
  logic [2:0] ev_sel;
  logic [7:0] ev_val, rd_hold = 8'h00, m_sv;
  logic [1:0] addr_exp;
  int         addr_lo = -1, addr_hi = -2, m_lat;
  bit         m_sh, m_hit;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", cmd_ready, 0);
      chk("rst_sel", rf_sel, 0);
      chk("rst_addr", rf_addr, 0);
      chk("rst_in", rf_in, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_err", err, 0);
      ev_kind = 0; addr_lo = -1; addr_hi = -2; ready_at = cyc + 2; rd_hold = 8'h00;
      for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    end else begin
      m_hit = (ev_kind != 0) && (cyc == ev_cyc);
      if (m_hit && ev_kind == KR) rd_hold = ev_val;
      chk("cmd_ready", cmd_ready, cyc >= ready_at);
      chk("rf_sel", rf_sel, (m_hit && ev_kind == KW) ? ev_sel : 3'b000);
      if (m_hit && ev_kind == KW) begin
        chk("rf_in", rf_in, ev_val);
        regs[ev_dst] = ev_val;
        vld[ev_dst]  = 1'b1;
      end
      chk("rd_valid", rd_valid, m_hit && ev_kind == KR);
      chk("rd_data", rd_data, rd_hold);
      chk("err", err, m_hit && ev_kind == KE);
      chk("rf_rz", rf_rz, 0);
      if (cyc >= addr_lo && cyc <= addr_hi) chk("rf_addr", rf_addr, addr_exp);
      if (cyc >= ready_at && cmd_valid) begin
        m_sv = (cmd_src == 2'd3) ? 8'h00 : regs[cmd_src];
        m_sh = SHADOW && ((cmd_src == 2'd3) || vld[cmd_src]);
        ev_sel = 3'b001 << cmd_dst;
        ev_dst = int'(cmd_dst);
        if (cmd_dst == 2'd3 && cmd_op != READ) begin
          ev_kind = KE; ev_cyc = cyc + 1; ready_at = cyc + 2;
        end else if (cmd_op == LOAD || cmd_op == CLEAR) begin
          ev_kind = KW; ev_cyc = cyc + 1; ready_at = cyc + 2;
          ev_val = (cmd_op == LOAD) ? cmd_imm : 8'h00;
        end else begin
          m_lat    = m_sh ? 2 : RD_LAT + 3;
          ev_kind  = (cmd_op == MOVE) ? KW : KR;
          ev_cyc   = cyc + m_lat - 1;
          ready_at = cyc + m_lat;
          ev_val   = m_sv;
          addr_exp = cmd_src;
          addr_lo  = cyc + 1;
          addr_hi  = m_sh ? cyc + 1 : cyc + RD_LAT + 1;
        end
      end
    end
    cyc++;
  end

  // Per-command observations gathered by send().
  int         t_lat, t_sel_n, t_rv_n, t_err_n;
  logic [2:0] t_sel;
  logic [7:0] t_in, t_rdv;

  task automatic send(input logic [1:0] op, dst, src, input logic [7:0] imm);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Garbage on the command bus while busy must be ignored.
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_dst = 2'($urandom);
    cmd_src = 2'($urandom); cmd_imm = 8'($urandom);
    t_lat = 0; t_sel_n = 0; t_rv_n = 0; t_err_n = 0; t_sel = '0; t_in = '0; t_rdv = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (|rf_sel) begin t_sel_n++; t_sel = rf_sel; t_in = rf_in; end
      if (rd_valid) begin t_rv_n++; t_rdv = rd_data; end
      if (err) t_err_n++;
      if (cmd_ready) begin t_lat = k; break; end
    end
    if (t_lat == 0) chk("done_timeout", cmd_ready, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready_lit", cmd_ready, 0);
    chk("reset_sel_lit", rf_sel, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    send(LOAD, 2'd1, 2'd0, 8'h5A);
    chk("t1_lat", t_lat, 2); chk("t1_sel_n", t_sel_n, 1);
    chk("t1_sel", t_sel, 3'b010); chk("t1_in", t_in, 8'h5A);

    send(LOAD, 2'd0, 2'd0, 8'h3C);
    send(MOVE, 2'd2, 2'd0, 8'h00);
    chk("t2_move_lat", t_lat, SHADOW ? 2 : RD_LAT + 3);
    chk("t2_sel", t_sel, 3'b100); chk("t2_in", t_in, 8'h3C);
    send(READ, 2'd0, 2'd2, 8'h00);
    chk("t2_rv_n", t_rv_n, 1); chk("t2_rdv", t_rdv, 8'h3C);

    send(READ, 2'd0, 2'd3, 8'h00);
    chk("t3_rz_rv_n", t_rv_n, 1); chk("t3_rz", t_rdv, 8'h00);
    send(CLEAR, 2'd1, 2'd0, 8'hEE);
    chk("t3_clr_in", t_in, 8'h00); chk("t3_clr_sel", t_sel, 3'b010);
    send(READ, 2'd0, 2'd1, 8'h00);
    chk("t3_rd_clr", t_rdv, 8'h00);

    send(LOAD, 2'd3, 2'd0, 8'hFF);
    chk("t4_err_n", t_err_n, 1); chk("t4_sel_n", t_sel_n, 0); chk("t4_lat", t_lat, 2);

    send(LOAD, 2'd0, 2'd0, 8'h99);
    send(MOVE, 2'd0, 2'd0, 8'h00);
    chk("same_move_in", t_in, 8'h99);
    send(READ, 2'd0, 2'd0, 8'h00);
    chk("same_move_rd", t_rdv, 8'h99);

    // Reset while the MOVE sits in its wait phase.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = MOVE; cmd_dst = 2'd2; cmd_src = 2'd0;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("t5_accept", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t5_sel_zero", rf_sel, 0); chk("t5_addr_zero", rf_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    t_sel_n = 0; t_rv_n = 0;
    repeat (6) @(negedge clk) begin
      if (|rf_sel) t_sel_n++;
      if (rd_valid) t_rv_n++;
    end
    chk("t5_no_write", t_sel_n, 0); chk("t5_no_rdvalid", t_rv_n, 0);

    send(LOAD, 2'd1, 2'd0, 8'h77);
    chk("t5_load_lat", t_lat, 2);
    send(READ, 2'd0, 2'd1, 8'h00);
    chk("t6_hit_lat", t_lat, SHADOW ? 2 : RD_LAT + 3); chk("t6_hit_rdv", t_rdv, 8'h77);
    send(READ, 2'd0, 2'd0, 8'h00);
    chk("t6_miss_lat", t_lat, RD_LAT + 3); chk("t6_miss_rdv", t_rdv, 8'h99);
    send(READ, 2'd0, 2'd2, 8'h00);
    chk("t5_r2_kept", t_rdv, 8'h3C);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      send(2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
